// File: rtl/bus_arbiter_if.sv
// Master-side and Bridge-side signals of the two-master bus arbiter.
interface bus_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              m0_req;
   logic              m1_req;
   logic              m0_lock;
   logic              m1_lock;
   logic [ADDR_W-1:0] m0_addr;
   logic [ADDR_W-1:0] m1_addr;
   logic              m0_we;
   logic              m1_we;
   logic [DATA_W-1:0] m0_wdata;
   logic [DATA_W-1:0] m1_wdata;
   logic              m0_gnt;
   logic              m1_gnt;
   logic              m0_ack;
   logic              m1_ack;
   logic [DATA_W-1:0] m0_rdata;
   logic [DATA_W-1:0] m1_rdata;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_we;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic [1:0]        arb_owner;
   logic              arb_busy;

   // Arbiter view
   modport slave (
      input  m0_req, m1_req, m0_lock, m1_lock, m0_addr, m1_addr,
             m0_we, m1_we, m0_wdata, m1_wdata, bus_rdata,
      output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
             bus_addr, bus_we, bus_wdata, arb_owner, arb_busy
   );

   // Requester / Bridge environment view
   modport master (
      output m0_req, m1_req, m0_lock, m1_lock, m0_addr, m1_addr,
             m0_we, m1_we, m0_wdata, m1_wdata, bus_rdata,
      input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdata, m1_rdata,
             bus_addr, bus_we, bus_wdata, arb_owner, arb_busy
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the single Bridge slave port,
// with bounded bus locking for read-modify-write sequences.
module bus_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic          cpu_clk,
   input  logic          cpu_rst_n,
   bus_arbiter_if.slave  bus
);
   // State encoding doubles as the arb_owner code
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   localparam int unsigned CNT_W     = 8;
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 32'd1);
   localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

   logic [1:0]       r_state;
   logic             r_last;      // 0: m0 served last, 1: m1 served last
   logic [CNT_W-1:0] r_lock_cnt;

   logic [1:0]       w_state_nxt;
   logic             w_last_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_own_req;
   logic             w_own_lock;
   logic             w_oth_req;
   logic             w_own_id;
   logic             w_gnt0;
   logic             w_gnt1;

   // State, last-served and lock counter registers
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         r_state    <= ST_IDLE;
         r_last     <= 1'b1;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_last     <= w_last_nxt;
         r_lock_cnt <= w_cnt_nxt;
      end
   end

   // Next-state arbitration and owner-selected bus multiplexing
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_lock_cnt;
      w_own_req   = 1'b0;
      w_own_lock  = 1'b0;
      w_oth_req   = 1'b0;
      w_own_id    = 1'b0;

      case (r_state)
         ST_OWN0: begin
            w_own_req  = bus.m0_req;
            w_own_lock = bus.m0_lock;
            w_oth_req  = bus.m1_req;
            w_own_id   = 1'b0;
         end
         ST_OWN1: begin
            w_own_req  = bus.m1_req;
            w_own_lock = bus.m1_lock;
            w_oth_req  = bus.m0_req;
            w_own_id   = 1'b1;
         end
         default: ;
      endcase

      if ((r_state == ST_OWN0) || (r_state == ST_OWN1)) begin
         // Hand over when contended unless a live lock still has budget left
         if (w_oth_req && (!w_own_lock || !w_own_req || (r_lock_cnt == LOCK_LAST))) begin
            w_state_nxt = w_own_id ? ST_OWN0 : ST_OWN1;
            w_last_nxt  = w_own_id;
            w_cnt_nxt   = '0;
         end else if (w_own_req) begin
            if (w_oth_req)
               w_cnt_nxt = (r_lock_cnt == CNT_SAT) ? r_lock_cnt : r_lock_cnt + CNT_W'(1);
            else
               w_cnt_nxt = '0;
         end else begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = w_own_id;
            w_cnt_nxt   = '0;
         end
      end else begin
         w_cnt_nxt = '0;
         case ({bus.m1_req, bus.m0_req})
            2'b01:   w_state_nxt = ST_OWN0;
            2'b10:   w_state_nxt = ST_OWN1;
            2'b11:   w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
            default: w_state_nxt = ST_IDLE;
         endcase
      end

      w_gnt0 = (r_state == ST_OWN0);
      w_gnt1 = (r_state == ST_OWN1);

      bus.m0_gnt    = w_gnt0;
      bus.m1_gnt    = w_gnt1;
      bus.m0_ack    = w_gnt0 & bus.m0_req;
      bus.m1_ack    = w_gnt1 & bus.m1_req;
      bus.m0_rdata  = w_gnt0 ? bus.bus_rdata : '0;
      bus.m1_rdata  = w_gnt1 ? bus.bus_rdata : '0;
      bus.bus_addr  = w_gnt0 ? bus.m0_addr  : (w_gnt1 ? bus.m1_addr  : '0);
      bus.bus_wdata = w_gnt0 ? bus.m0_wdata : (w_gnt1 ? bus.m1_wdata : '0);
      // A granted master that is not requesting must never write
      bus.bus_we    = (w_gnt0 & bus.m0_req & bus.m0_we) | (w_gnt1 & bus.m1_req & bus.m1_we);
      bus.arb_owner = r_state;
      bus.arb_busy  = (r_state != ST_IDLE);
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared against a behavioural arbitration model.
module tb_bus_arbiter;
   localparam int unsigned AW       = 32;
   localparam int unsigned DW       = 32;
   localparam int unsigned LOCK_MAX = 4;
   localparam int          N_RAND   = 10000;

   logic cpu_clk = 1'b0;
   logic cpu_rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   wr_count = 0;

   bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

   bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst_n (cpu_rst_n),
      .bus       (ifc)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Bridge model: a write commits on the edge that ends a cycle with bus_we high
   always @(posedge cpu_clk) begin
      if (ifc.bus_we) wr_count <= wr_count + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      ifc.m0_req = 0; ifc.m1_req = 0; ifc.m0_lock = 0; ifc.m1_lock = 0;
      ifc.m0_we = 0; ifc.m1_we = 0; ifc.m0_addr = '0; ifc.m1_addr = '0;
      ifc.m0_wdata = '0; ifc.m1_wdata = '0; ifc.bus_rdata = '0;
   endtask

   task automatic next_cycle();
      @(posedge cpu_clk);
      #1;
   endtask

   // Leaves the bench 1 time unit after an edge with the arbiter idle
   task automatic do_reset();
      cpu_rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      cpu_rst_n = 1'b0;
      idle_inputs();
      ifc.m0_req = 1; ifc.m1_req = 1; ifc.m0_we = 1; ifc.m1_we = 1;
      ifc.m0_addr = 32'h1234; ifc.m1_addr = 32'h5678; ifc.bus_rdata = 32'hDEAD;
      repeat (2) @(posedge cpu_clk);
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.m0_gnt, ifc.m1_gnt, ifc.m0_ack, ifc.m1_ack, ifc.bus_we, ifc.arb_busy} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: gnt0/gnt1/ack0/ack1/we/busy=%b want 000000",
                  {ifc.m0_gnt, ifc.m1_gnt, ifc.m0_ack, ifc.m1_ack, ifc.bus_we, ifc.arb_busy});
      end
      n_checks++;
      if (ifc.arb_owner !== 2'd0) begin
         n_fail++; $display("FAIL reset_owner: got %0d want 0", ifc.arb_owner);
      end
      n_checks++;
      if ({ifc.bus_addr, ifc.bus_wdata, ifc.m0_rdata, ifc.m1_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%h wdata=%h rd0=%h rd1=%h want all 0",
                  ifc.bus_addr, ifc.bus_wdata, ifc.m0_rdata, ifc.m1_rdata);
      end
   endtask

   task automatic test_single_write();
      int w0;
      do_reset();
      ifc.m0_req = 1; ifc.m0_we = 1; ifc.m0_addr = 32'hFFFFF000; ifc.m0_wdata = 32'h12345678;
      @(negedge cpu_clk);
      n_checks++;
      if (ifc.m0_gnt !== 1'b0) begin
         n_fail++; $display("FAIL write_latency: m0_gnt=%b in request cycle, want 0", ifc.m0_gnt);
      end
      w0 = wr_count;
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         @(negedge cpu_clk);
         n_checks++;
         if ({ifc.m0_gnt, ifc.m0_ack, ifc.bus_we, ifc.m1_gnt} !== 4'b1110) begin
            n_fail++;
            $display("FAIL write_beat%0d: gnt0/ack0/we/gnt1=%b want 1110", k,
                     {ifc.m0_gnt, ifc.m0_ack, ifc.bus_we, ifc.m1_gnt});
         end
         n_checks++;
         if ({ifc.bus_addr, ifc.bus_wdata, ifc.arb_owner} !== {32'hFFFFF000, 32'h12345678, 2'd1}) begin
            n_fail++;
            $display("FAIL write_bus%0d: addr=%h wdata=%h owner=%0d want fffff000 12345678 1",
                     k, ifc.bus_addr, ifc.bus_wdata, ifc.arb_owner);
         end
         next_cycle();
      end
      ifc.m0_req = 0;
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.m0_gnt, ifc.m0_ack, ifc.bus_we} !== 3'b100) begin
         n_fail++;
         $display("FAIL write_drop: gnt0/ack0/we=%b want 100", {ifc.m0_gnt, ifc.m0_ack, ifc.bus_we});
      end
      next_cycle();
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.arb_owner, ifc.arb_busy, ifc.bus_we, ifc.bus_addr, ifc.bus_wdata} !== '0) begin
         n_fail++;
         $display("FAIL write_idle: owner=%0d busy=%b we=%b addr=%h wdata=%h want all 0",
                  ifc.arb_owner, ifc.arb_busy, ifc.bus_we, ifc.bus_addr, ifc.bus_wdata);
      end
      n_checks++;
      if (wr_count - w0 != 3) begin
         n_fail++; $display("FAIL write_count: got %0d writes want 3", wr_count - w0);
      end
   endtask

   task automatic test_alternate();
      do_reset();
      ifc.m0_req = 1; ifc.m1_req = 1;
      ifc.m0_addr = 32'hA0; ifc.m1_addr = 32'hB0;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         @(negedge cpu_clk);
         n_checks++;
         if ({ifc.m0_ack, ifc.m1_ack, ifc.m0_gnt, ifc.m1_gnt} !== ((k % 2 == 0) ? 4'b1010 : 4'b0101)) begin
            n_fail++;
            $display("FAIL alternate%0d: ack0/ack1/gnt0/gnt1=%b want %b", k,
                     {ifc.m0_ack, ifc.m1_ack, ifc.m0_gnt, ifc.m1_gnt},
                     (k % 2 == 0) ? 4'b1010 : 4'b0101);
         end
      end
      idle_inputs();
   endtask

   task automatic test_lock();
      int  acks0;
      bit  seen;
      do_reset();
      ifc.m0_req = 1; ifc.m0_lock = 1;
      next_cycle();
      ifc.m1_req = 1;
      acks0 = 0;
      seen  = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge cpu_clk);
         n_checks++;
         if ((ifc.m0_ack | ifc.m1_ack) !== 1'b1) begin
            n_fail++; $display("FAIL lock_bubble%0d: no ack in contended cycle", k);
         end
         if (ifc.m1_gnt === 1'b1) seen = 1;
         else begin
            if (ifc.m0_ack === 1'b1) acks0++;
            next_cycle();
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL lock_handover: m1_gnt=0 after 20 cycles want 1");
      end
      n_checks++;
      if (acks0 != LOCK_MAX) begin
         n_fail++; $display("FAIL lock_beats: got %0d m0 acks want %0d", acks0, LOCK_MAX);
      end
      idle_inputs();
   endtask

   task automatic test_read();
      do_reset();
      ifc.m1_req = 1; ifc.m1_we = 0; ifc.m1_addr = 32'hFFFFF070; ifc.bus_rdata = 32'h00ABCDEF;
      ifc.m0_addr = 32'h0000_1111;
      next_cycle();
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.m1_gnt, ifc.m1_ack, ifc.m0_gnt, ifc.arb_owner} !== {3'b110, 2'd2}) begin
         n_fail++;
         $display("FAIL read_grant: gnt1/ack1/gnt0=%b owner=%0d want 110 2",
                  {ifc.m1_gnt, ifc.m1_ack, ifc.m0_gnt}, ifc.arb_owner);
      end
      n_checks++;
      if ({ifc.m1_rdata, ifc.m0_rdata, ifc.bus_addr} !== {32'h00ABCDEF, 32'h0, 32'hFFFFF070}) begin
         n_fail++;
         $display("FAIL read_data: rd1=%h rd0=%h addr=%h want 00abcdef 0 fffff070",
                  ifc.m1_rdata, ifc.m0_rdata, ifc.bus_addr);
      end
      next_cycle();
      ifc.m1_req = 0; ifc.m1_we = 1;
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.m1_gnt, ifc.m1_ack, ifc.bus_we} !== 3'b100) begin
         n_fail++;
         $display("FAIL read_drop: gnt1/ack1/we=%b want 100", {ifc.m1_gnt, ifc.m1_ack, ifc.bus_we});
      end
      next_cycle();
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.arb_owner, ifc.m1_rdata} !== '0) begin
         n_fail++;
         $display("FAIL read_idle: owner=%0d rd1=%h want 0 0", ifc.arb_owner, ifc.m1_rdata);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      int w0;
      do_reset();
      ifc.m0_req = 1; ifc.m0_we = 1; ifc.m0_addr = 32'hFFFFF000; ifc.m0_wdata = 32'hCAFE0001;
      w0 = wr_count;
      next_cycle();
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.m0_gnt, ifc.bus_we} !== 2'b11) begin
         n_fail++; $display("FAIL rstmid_pre: gnt0/we=%b want 11", {ifc.m0_gnt, ifc.bus_we});
      end
      #1 cpu_rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ifc.m0_gnt, ifc.m0_ack, ifc.bus_we} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstmid_async: gnt0/ack0/we=%b want 000", {ifc.m0_gnt, ifc.m0_ack, ifc.bus_we});
      end
      next_cycle();
      n_checks++;
      if (wr_count != w0) begin
         n_fail++; $display("FAIL rstmid_commit: got %0d writes want 0", wr_count - w0);
      end
      ifc.m0_we = 0; ifc.m1_req = 1;
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
      next_cycle();
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.m0_gnt, ifc.m1_gnt} !== 2'b10) begin
         n_fail++; $display("FAIL rstmid_first: gnt0/gnt1=%b want 10", {ifc.m0_gnt, ifc.m1_gnt});
      end
      next_cycle();
      @(negedge cpu_clk);
      n_checks++;
      if ({ifc.m0_gnt, ifc.m1_gnt} !== 2'b01) begin
         n_fail++; $display("FAIL rstmid_second: gnt0/gnt1=%b want 01", {ifc.m0_gnt, ifc.m1_gnt});
      end
      idle_inputs();
   endtask

   task automatic test_random();
      // Model: owner index (-1 idle), index served last, contended beats granted so far
      int          owner = -1;
      int          last = 1;
      int          beats = 0;
      bit          req[2], lock[2], we[2], exp_gnt[2], exp_ack[2], hand_over;
      logic [31:0] addr[2], wdata[2], rdata, exp_addr, exp_wdata;
      logic [1:0]  exp_owner;
      bit          exp_we;
      int          start[2];
      int          o, t;
      do_reset();
      for (int i = 0; i < 2; i++) begin req[i] = 0; start[i] = 0; end
      for (int cyc = 0; cyc < N_RAND; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!req[i] && ($urandom_range(0, 99) < 50)) begin req[i] = 1; start[i] = cyc; end
            lock[i]  = ($urandom_range(0, 99) < 40);
            we[i]    = $urandom_range(0, 1) == 1;
            addr[i]  = $urandom;
            wdata[i] = $urandom;
         end
         rdata = $urandom;
         ifc.m0_req = req[0]; ifc.m1_req = req[1]; ifc.m0_lock = lock[0]; ifc.m1_lock = lock[1];
         ifc.m0_we = we[0]; ifc.m1_we = we[1]; ifc.m0_addr = addr[0]; ifc.m1_addr = addr[1];
         ifc.m0_wdata = wdata[0]; ifc.m1_wdata = wdata[1]; ifc.bus_rdata = rdata;

         for (int i = 0; i < 2; i++) begin
            exp_gnt[i] = (owner == i);
            exp_ack[i] = exp_gnt[i] && req[i];
         end
         exp_addr  = (owner >= 0) ? addr[owner]  : 32'h0;
         exp_wdata = (owner >= 0) ? wdata[owner] : 32'h0;
         exp_we    = (owner >= 0) && req[owner] && we[owner];
         exp_owner = 2'(owner + 1);

         @(negedge cpu_clk);
         n_checks++;
         if ({ifc.m0_gnt, ifc.m1_gnt, ifc.m0_ack, ifc.m1_ack} !== {exp_gnt[0], exp_gnt[1], exp_ack[0], exp_ack[1]}) begin
            n_fail++;
            $display("FAIL rand_gnt_ack c%0d: gnt0/gnt1/ack0/ack1=%b want %b", cyc,
                     {ifc.m0_gnt, ifc.m1_gnt, ifc.m0_ack, ifc.m1_ack},
                     {exp_gnt[0], exp_gnt[1], exp_ack[0], exp_ack[1]});
         end
         n_checks++;
         if ({ifc.bus_addr, ifc.bus_wdata, ifc.bus_we} !== {exp_addr, exp_wdata, exp_we}) begin
            n_fail++;
            $display("FAIL rand_bus c%0d: addr=%h wdata=%h we=%b want %h %h %b", cyc,
                     ifc.bus_addr, ifc.bus_wdata, ifc.bus_we, exp_addr, exp_wdata, exp_we);
         end
         n_checks++;
         if ({ifc.m0_rdata, ifc.m1_rdata} !== {exp_gnt[0] ? rdata : 32'h0, exp_gnt[1] ? rdata : 32'h0}) begin
            n_fail++;
            $display("FAIL rand_rdata c%0d: rd0=%h rd1=%h bus_rdata=%h owner=%0d", cyc,
                     ifc.m0_rdata, ifc.m1_rdata, rdata, owner);
         end
         n_checks++;
         if ({ifc.arb_owner, ifc.arb_busy} !== {exp_owner, owner >= 0}) begin
            n_fail++;
            $display("FAIL rand_owner c%0d: owner=%0d busy=%b want %0d %b", cyc,
                     ifc.arb_owner, ifc.arb_busy, exp_owner, owner >= 0);
         end
         n_checks++;
         if ((ifc.m0_gnt & ifc.m1_gnt) !== 1'b0 ||
             (ifc.m0_ack & !(ifc.m0_gnt & req[0])) !== 1'b0 ||
             (ifc.m1_ack & !(ifc.m1_gnt & req[1])) !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_safety c%0d: gnt=%b%b ack=%b%b req=%b%b", cyc,
                     ifc.m0_gnt, ifc.m1_gnt, ifc.m0_ack, ifc.m1_ack, req[0], req[1]);
         end
         for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
               n_checks++;
               if (cyc - start[i] > int'(LOCK_MAX) + 1) begin
                  n_fail++;
                  $display("FAIL rand_starve c%0d: m%0d waiting %0d cycles want <= %0d",
                           cyc, i, cyc - start[i], LOCK_MAX + 1);
               end
            end
         end

         // Arbitration rules applied at the closing edge
         if (owner < 0) begin
            if (req[0] && req[1]) owner = 1 - last;
            else if (req[0])      owner = 0;
            else if (req[1])      owner = 1;
            beats = 0;
         end else begin
            o = owner;
            t = 1 - owner;
            hand_over = req[t] && (!req[o] || !lock[o] || (beats + 1 >= int'(LOCK_MAX)));
            if (hand_over) begin
               last = o; owner = t; beats = 0;
            end else if (req[o]) begin
               beats = req[t] ? ((beats < 255) ? beats + 1 : 255) : 0;
            end else begin
               last = o; owner = -1; beats = 0;
            end
         end

         // Acked masters either issue a new beat next cycle or go quiet
         for (int i = 0; i < 2; i++) begin
            if (exp_ack[i]) begin
               req[i]   = ($urandom_range(0, 99) < 60);
               start[i] = cyc + 1;
            end
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_write();
      test_alternate();
      test_lock();
      test_read();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master round-robin arbiter placed between the bus requesters (miniRV core data port and a second master such as the planned button/DMA engine) and the single Bridge slave port. It grants the shared Bridge port to one master at a time and multiplexes that master's address, write enable and write data onto the bus. It returns read data and a per-beat acknowledge, and supports short locked sequences for read-modify-write on peripherals.

## Interface
- ADDR_W, 32, address width of masters and bus
- DATA_W, 32, data width of masters and bus
- LOCK_MAX, 16, maximum consecutive beats a locking master may hold the bus while the other master requests (range 1..255)

- cpu_clk  in  1  system clock; all state on rising edge
- cpu_rst_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  master requests a beat this cycle
- m0_lock / m1_lock  in  1  master asks to keep the bus after this beat
- m0_addr / m1_addr  in  ADDR_W  beat address
- m0_we / m1_we  in  1  beat is a write
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  master currently owns the bus (registered)
- m0_ack / m1_ack  out  1  beat completes this cycle (gnt & req, combinational)
- m0_rdata / m1_rdata  out  DATA_W  bus_rdata when owner, else 0
- bus_addr  out  ADDR_W  to Bridge addr_from_cpu
- bus_we  out  1  to Bridge we_from_cpu
- bus_wdata  out  DATA_W  to Bridge wdata_from_cpu
- bus_rdata  in  DATA_W  from Bridge rdata_to_cpu (combinational slave)
- arb_owner  out  2  0 idle, 1 = m0, 2 = m1
- arb_busy  out  1  arb_owner != 0

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, last_served (1 bit), lock_cnt (8 bit).
- IDLE: only m0_req → OWN0; only m1_req → OWN1; both → grant the master != last_served; none → stay.
- OWNx, end of cycle, with "other" = the opposite master:
  - other requesting and (!mx_lock or lock_cnt == LOCK_MAX-1 at a beat or !mx_req) → OWN(other), last_served = x, lock_cnt = 0.
  - else mx_req → stay in OWNx; lock_cnt += 1 (saturating) on each beat while other_req is high, else lock_cnt = 0.
  - else (no requests) → IDLE, last_served = x, lock_cnt = 0.
- Beat: ack = gnt & req. Bus fields come from the owner. bus_we = owner_req & owner_we, so a granted master that drops req cannot write.
- IDLE: bus_addr = 0, bus_we = 0, bus_wdata = 0, both rdata = 0.
- A lock is honoured only while the owner keeps req high. Lock is ignored with no contention (owner parks anyway).
- Reset values: state IDLE, last_served = 1 (m0 wins first contention), lock_cnt 0, all gnt/ack 0, arb_owner 0, arb_busy 0, bus outputs 0.

## Timing
- Grant latency: req seen in IDLE at edge N → gnt high after edge N, first ack in the same cycle if req still high (1 cycle req→ack).
- Owner switch has no idle bubble: last beat of A in cycle k, B's gnt/ack in cycle k+1.
- Throughput: one beat per cycle for a parked owner.
- Reads: rdata is valid in the ack cycle (Bridge is combinational). Writes commit at the edge ending the ack cycle.
- Simultaneous first request from both masters after reset: m0 first, m1 next.
- Reset asserted mid-beat: gnt, ack and bus_we fall asynchronously. No write commits on the following edge.
- No master can be starved: with continuous contention, the worst-case wait is LOCK_MAX beats.

## Test plan
- Reset release, m0_req steady, write addr 0xFFFFF000 data 0x12345678 → cycle 1: m0_gnt=1, m0_ack=1, bus_we=1, bus_addr=0xFFFFF000. arb_owner=1 until req drops, then IDLE with all bus outputs 0.
- Both req from IDLE, no lock → alternating acks m0,m1,m0,m1 on consecutive cycles, never both gnt.
- m0 holds lock with m1 requesting, LOCK_MAX=4 → exactly 4 m0 acks, then m1_gnt in the next cycle with no idle cycle.
- m1 granted and parked, reads addr 0xFFFFF070 with bus_rdata=0x00ABCDEF → m1_rdata=0x00ABCDEF, m0_rdata=0. m1 drops req while granted → bus_we=0 that cycle, state → IDLE.
- cpu_rst_n pulled low in a write-ack cycle → bus_we and gnt go 0 before the next edge; Bridge model records no write; after release, m0 wins contention.
- Random req/lock/we traffic over 10k cycles → at most one gnt, ack implies gnt & req, and every requester is acked within LOCK_MAX+1 cycles of raising req.
